// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first, idle high) fed by a small byte FIFO.
// Frames are sent back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          udata,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [BW-1:0]   r_baud;
    logic [BW-1:0]   w_baud_nx;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_nx;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nx;
    logic            r_udata;
    logic            w_udata_nx;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_bit_end;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_push    = in_valid && !w_full;
    assign w_bit_end = (r_baud == BAUD_MAX);

    assign in_ready   = !w_full;
    assign udata      = r_udata;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign fifo_count = r_count;

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = w_bit_end ? '0 : r_baud + BW'(1);
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_udata_nx = r_udata;
        w_pop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_baud_nx  = '0;
                w_udata_nx = 1'b1;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rptr];
                    w_state_nx = START;
                    w_udata_nx = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nx = DATA;
                    w_bit_nx   = 3'd0;
                    w_udata_nx = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_nx = STOP;
                        w_udata_nx = 1'b1;
                    end else begin
                        w_bit_nx   = r_bit + 3'd1;
                        w_udata_nx = r_shift[r_bit + 3'd1];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    // Chain straight into the next start bit when data waits.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = r_mem[r_rptr];
                        w_state_nx = START;
                        w_udata_nx = 1'b0;
                    end else begin
                        w_state_nx = IDLE;
                        w_udata_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_udata_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_udata <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_udata <= w_udata_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: per-cycle comparison of the line, busy,
// count and ready against a frame-timing model built from byte queues.
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FL    = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       udata;
    logic       busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .udata     (udata),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Model: bytes waiting, the byte on the line, its start edge, and the
    // first edge at which the line is free for a new start bit.
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int         s = -100000;
    int         next_free = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, n);
        end
    endtask

    function automatic logic frame_active();
        return (n - s >= 0) && (n - s < FL);
    endfunction

    function automatic logic exp_line();
        int b;
        if (!frame_active()) return 1'b1;
        b = (n - s) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cur[b-1];
    endfunction

    task automatic check_all(input string pfx);
        chk({pfx, "_udata"}, udata, exp_line());
        chk({pfx, "_busy"}, busy, frame_active() || (q.size() > 0));
        chk({pfx, "_count"}, fifo_count, q.size());
        chk({pfx, "_ready"}, in_ready, q.size() < DEPTH);
    endtask

    task automatic step();
        int sz;
        @(posedge clk);
        n++;
        if (!rst) begin
            sz = q.size();
            if (sz > 0 && n >= next_free) begin
                cur = q.pop_front();
                s = n;
                next_free = n + FL;
            end
            if (in_valid && sz < DEPTH) q.push_back(in_data);
        end
        #1;
        check_all("cyc");
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) step();
    endtask

    task automatic push1(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        s = -100000;
        next_free = 0;
        chk("rst_udata", udata, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ready", in_ready, 1'b1);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int i;
        int guard;
        logic acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2;
        do_reset();

        push1(8'h55);
        chk("t1_count1", fifo_count, 3'd1);
        step();
        chk("t1_start", udata, 1'b0);
        idle(FL + 20);
        chk("t1_done", busy, 1'b0);

        in_valid = 1'b1;
        in_data = 8'hA3; step();
        in_data = 8'h00; step();
        in_data = 8'hFF; step();
        idle(3 * FL + 10);

        in_valid = 1'b1;
        i = 0;
        guard = 0;
        while (i < 6 && guard < 2000) begin
            in_data = 8'h10 + 8'(i);
            acc = q.size() < DEPTH;
            step();
            if (acc) i++;
            guard++;
        end
        chk("t3_timeout", guard < 2000, 1'b1);
        idle(7 * FL);

        in_valid = 1'b1;
        in_data = 8'hC1; step();
        in_data = 8'hC2; step();
        in_data = 8'hC3; step();
        in_valid = 1'b0;
        while (n < s + FL - 1) step();
        push1(8'hC4);
        chk("t4_coincide", fifo_count, 3'd2);
        idle(4 * FL);

        push1(8'h3C);
        idle(41);
        do_reset();
        push1(8'h81);
        idle(FL + 10);
        chk("t5_idle", udata, 1'b1);

        repeat (3000) begin
            in_valid = ($urandom_range(0, 9) < 2);
            in_data  = 8'($urandom);
            step();
        end
        idle(6 * FL);
        chk("drain_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
